// File: rtl/unidade_controle_pkg.sv
// rtl/unidade_controle_pkg.sv - shared opcodes, register control codes, ULA selects and FSM states
package unidade_controle_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_LDX = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  localparam logic [4:0] REG_CLEAR  = 5'd0;
  localparam logic [4:0] REG_LOAD   = 5'd1;
  localparam logic [4:0] REG_HOLD   = 5'd2;
  localparam logic [4:0] REG_SHIFTL = 5'd3;

  localparam logic [1:0] ULA_ADD  = 2'd0;
  localparam logic [1:0] ULA_SUB  = 2'd1;
  localparam logic [1:0] ULA_PASS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_CLR,
    S_MUL_SHIFT,
    S_MUL_ADD,
    S_DONE
  } state_t;

endpackage

// File: rtl/unidade_controle_contador_iter.sv
// rtl/unidade_controle_contador_iter.sv - multiply iteration counter, terminal flag at N_BITS-1
module contador_iter
  import unidade_controle_pkg::*;
#(
  parameter int N_BITS = 5,
  parameter int CW     = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count;

  // Saturates at the terminal value so narrow widths never wrap back to zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(N_BITS - 1));

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - X/Y/Z datapath control FSM; UNIDADE_CONTROLE_MUL_EN enables shift-and-add MUL
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int N_BITS = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       mult_bit,
  output logic [4:0] tx,
  output logic [4:0] ty,
  output logic [4:0] tz,
  output logic [1:0] sel_ula,
  output logic       busy,
  output logic       done
);

  state_t     state, state_next;
  logic [2:0] op_q;

`ifdef UNIDADE_CONTROLE_MUL_EN
  logic cnt_clr, cnt_inc, cnt_last;

  contador_iter #(.N_BITS(N_BITS)) u_contador_iter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .last    (cnt_last)
  );
`else
  logic unused_mult_bit;
  assign unused_mult_bit = mult_bit;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= OP_NOP;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_next = state;
    tx         = REG_HOLD;
    ty         = REG_HOLD;
    tz         = REG_HOLD;
    sel_ula    = ULA_PASS;
    busy       = (state != S_IDLE);
    done       = 1'b0;
`ifdef UNIDADE_CONTROLE_MUL_EN
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef UNIDADE_CONTROLE_MUL_EN
          state_next = (opcode == OP_MUL) ? S_MUL_CLR : S_EXEC;
`else
          state_next = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_CLR: begin
            tx = REG_CLEAR;
            ty = REG_CLEAR;
            tz = REG_CLEAR;
          end
          OP_LDX: tx = REG_LOAD;
          OP_ADD: begin
            ty      = REG_LOAD;
            sel_ula = ULA_ADD;
          end
          OP_SUB: begin
            ty      = REG_LOAD;
            sel_ula = ULA_SUB;
          end
          OP_SHL: ty = REG_SHIFTL;
          // MUL only lands here when the multiplier is not built.
          OP_NOP, OP_MUL, OP_RSV: ;
          default: ;
        endcase
        state_next = S_DONE;
      end
`ifdef UNIDADE_CONTROLE_MUL_EN
      S_MUL_CLR: begin
        ty         = REG_CLEAR;
        cnt_clr    = 1'b1;
        state_next = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        ty         = REG_SHIFTL;
        state_next = S_MUL_ADD;
      end
      S_MUL_ADD: begin
        tx      = REG_SHIFTL;
        cnt_inc = 1'b1;
        if (mult_bit) begin
          ty      = REG_LOAD;
          sel_ula = ULA_ADD;
        end
        state_next = cnt_last ? S_DONE : S_MUL_SHIFT;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard bench for unidade_controle (both UNIDADE_CONTROLE_MUL_EN builds)
module tb_unidade_controle;

  localparam int NB = 5;
  localparam logic [4:0] C_CLEAR = 5'd0, C_LOAD = 5'd1, C_HOLD = 5'd2, C_SHL = 5'd3;
  localparam logic [1:0] U_ADD = 2'd0, U_SUB = 2'd1, U_PASS = 2'd2;

  typedef struct packed {
    logic [4:0] tx;
    logic [4:0] ty;
    logic [4:0] tz;
    logic [1:0] sel;
    logic       busy;
    logic       done;
  } word_t;

  logic       clock = 1'b0;
  logic       reset_n, start, mult_bit;
  logic [2:0] opcode;
  logic [4:0] tx, ty, tz;
  logic [1:0] sel_ula;
  logic       busy, done;

  word_t exp_q[$];
  bit    mon_en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  unidade_controle #(.N_BITS(NB)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .opcode   (opcode),
    .mult_bit (mult_bit),
    .tx       (tx),
    .ty       (ty),
    .tz       (tz),
    .sel_ula  (sel_ula),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic word_t mk(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                               input logic [1:0] s, input logic b, input logic d);
    word_t w;
    w.tx = x; w.ty = y; w.tz = z; w.sel = s; w.busy = b; w.done = d;
    return w;
  endfunction

  // Monitor: busy cycles consume one expected control word; idle cycles must show
  // the quiescent word with nothing left outstanding.
  always @(negedge clock) begin
    word_t got, exp;
    if (mon_en) begin
      got = mk(tx, ty, tz, sel_ula, busy, done);
      vectors++;
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_busy: got %h required idle %h", got, mk(C_HOLD, C_HOLD, C_HOLD, U_PASS, 0, 0));
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL busy_cycle: got %h required %h", got, exp);
          end
        end
      end else begin
        exp = mk(C_HOLD, C_HOLD, C_HOLD, U_PASS, 0, 0);
        if (got !== exp || exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL idle_cycle: got %h outstanding %0d required %h outstanding 0", got, exp_q.size(), exp);
          exp_q.delete();
        end
      end
    end
  end

  // bits[NB-1] is the multiplier bit of the first iteration.
  task automatic run_op(input logic [2:0] op, input logic [NB-1:0] bits, input bit noise);
    word_t seq[$];
    logic  mbs[$];
    bit    is_mul;
`ifdef UNIDADE_CONTROLE_MUL_EN
    is_mul = (op == 3'd6);
`else
    is_mul = 1'b0;
`endif
    if (is_mul) begin
      seq.push_back(mk(C_HOLD, C_CLEAR, C_HOLD, U_PASS, 1, 0));
      mbs.push_back(1'($urandom));
      for (int i = 0; i < NB; i++) begin
        seq.push_back(mk(C_HOLD, C_SHL, C_HOLD, U_PASS, 1, 0));
        mbs.push_back(1'($urandom));
        if (bits[NB-1-i]) seq.push_back(mk(C_SHL, C_LOAD, C_HOLD, U_ADD, 1, 0));
        else              seq.push_back(mk(C_SHL, C_HOLD, C_HOLD, U_PASS, 1, 0));
        mbs.push_back(bits[NB-1-i]);
      end
    end else begin
      case (op)
        3'd1:    seq.push_back(mk(C_CLEAR, C_CLEAR, C_CLEAR, U_PASS, 1, 0));
        3'd2:    seq.push_back(mk(C_LOAD, C_HOLD, C_HOLD, U_PASS, 1, 0));
        3'd3:    seq.push_back(mk(C_HOLD, C_LOAD, C_HOLD, U_ADD, 1, 0));
        3'd4:    seq.push_back(mk(C_HOLD, C_LOAD, C_HOLD, U_SUB, 1, 0));
        3'd5:    seq.push_back(mk(C_HOLD, C_SHL, C_HOLD, U_PASS, 1, 0));
        default: seq.push_back(mk(C_HOLD, C_HOLD, C_HOLD, U_PASS, 1, 0));
      endcase
      mbs.push_back(1'($urandom));
    end
    seq.push_back(mk(C_HOLD, C_HOLD, C_HOLD, U_PASS, 1, 1));
    mbs.push_back(1'($urandom));

    start = 1'b1; opcode = op; mult_bit = 1'($urandom);
    @(posedge clock); #1;
    foreach (seq[i]) exp_q.push_back(seq[i]);
    for (int k = 0; k < mbs.size(); k++) begin
      start    = noise ? 1'($urandom) : 1'b0;
      opcode   = 3'($urandom);
      mult_bit = mbs[k];
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; opcode = 3'($urandom); mult_bit = 1'($urandom);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 3'd0; mult_bit = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    run_op(3'd3, '0, 1'b0);
    idle(1);
    run_op(3'd5, '0, 1'b0);
    run_op(3'd4, '0, 1'b0);
    idle(2);
    run_op(3'd6, 5'b10110, 1'b1);
    run_op(3'd6, 5'b01001, 1'b0);
    run_op(3'd7, '0, 1'b1);
    run_op(3'd1, '0, 1'b0);
    run_op(3'd2, '0, 1'b0);
    run_op(3'd0, '0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom), NB'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    // Reset mid-operation, with start high on the reset edges.
    mon_en = 1'b0;
    start = 1'b1; opcode = 3'd6;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mult_bit = 1'($urandom);
      @(posedge clock); #1;
    end
    reset_n = 1'b0; start = 1'b1; opcode = 3'd3;
    @(posedge clock); #1;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1; start = 1'b0;
    idle(16);

    run_op(3'd3, '0, 1'b0);
    run_op(3'd6, 5'b11111, 1'b1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Control unit for the X/Y/Z register datapath. It accepts one opcode per `start` pulse and sequences the per-register control codes (`tx`, `ty`, `tz`) and the ULA operation select `sel_ula`, so the datapath registers clear, load or shift on the correct edges. It drives `ty` of the Y accumulator register directly, and every other register control port in the datapath. It also runs a multi-cycle shift-and-add multiply.

## Interface
- `N_BITS`, default 5: datapath width; the MUL opcode runs `N_BITS` iterations.
- `clock` input 1: single clock; everything updates on posedge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: request strobe; sampled only in IDLE.
- `opcode` input 3: operation, latched when `start` is accepted.
- `mult_bit` input 1: MSB of the X register (multiplier bit), used only in MUL_ADD.
- `tx`, `ty`, `tz` output 5 each: register control codes. CLEAR=0, LOAD=1, HOLD=2 (register retains its value), SHIFTL=3.
- `sel_ula` output 2: ULA operation. ADD=0, SUB=1, PASS=2.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- Opcodes:
  - 0 NOP
  - 1 CLR: tx=ty=tz=CLEAR
  - 2 LDX: tx=LOAD, sel_ula=PASS
  - 3 ADD: ty=LOAD, sel_ula=ADD
  - 4 SUB: ty=LOAD, sel_ula=SUB
  - 5 SHL: ty=SHIFTL
  - 6 MUL
  - 7 reserved, executes as NOP
- Any code not named for an opcode outputs HOLD; `sel_ula` defaults to PASS.
- States: IDLE, EXEC, MUL_CLR, MUL_SHIFT, MUL_ADD, DONE.
- IDLE:
  - `start`=1 with opcode 6 → MUL_CLR.
  - `start`=1 with any other opcode → EXEC.
  - `start`=0 → stay in IDLE.
  - Opcode is latched on the accepting edge.
- EXEC: drives the opcode's codes for exactly one cycle → DONE.
- MUL_CLR: ty=CLEAR, iteration counter ← 0 → MUL_SHIFT.
- MUL_SHIFT: ty=SHIFTL → MUL_ADD.
- MUL_ADD:
  - tx=SHIFTL.
  - If `mult_bit`=1: ty=LOAD, sel_ula=ADD. If `mult_bit`=0: ty=HOLD.
  - Counter increments.
  - Counter = `N_BITS`-1 → DONE; otherwise → MUL_SHIFT.
- DONE: `done`=1, all codes HOLD → IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored and has no queued effect.
- Outputs are a Moore decode of state and latched opcode. The only exception is `ty`/`sel_ula` in MUL_ADD, which follow `mult_bit` combinationally.
- Counter width is clog2(`N_BITS`); it never wraps inside one operation.

## Timing
- Reset (`reset_n`=0 at posedge), values from the next cycle:
  - state=IDLE, counter=0, opcode register=0
  - tx=ty=tz=HOLD, sel_ula=PASS, busy=0, done=0
- Reset during any state, including mid-MUL, aborts the operation: no DONE pulse, and datapath contents are not restored.
- Single-cycle opcode latency:
  - `start` edge → EXEC codes valid for 1 cycle → register acts on the following edge.
  - `done` high in the cycle after EXEC.
  - `start` to `done` = 2 cycles.
- MUL: 1 (MUL_CLR) + 2·`N_BITS` cycles + 1 DONE cycle = 12 cycles for `N_BITS`=5.
- `start` may be reasserted in the cycle after DONE (the first IDLE cycle). The new operation is accepted on that edge, so back-to-back throughput is one operation per 3 cycles for single-cycle opcodes.
- `start` and `reset_n`=0 on the same edge: reset wins.

## Configuration
- `UNIDADE_CONTROLE_MUL_EN` defined: opcode 6 runs the MUL sequence; MUL states and counter are present.
- Not defined:
  - Opcode 6 decodes as NOP through EXEC/DONE (2 cycles, all HOLD).
  - MUL states and counter are not synthesized.
  - `mult_bit` is unused.

## Structure
- Package `unidade_controle_pkg` holds:
  - opcode constants;
  - register codes CLEAR/LOAD/HOLD/SHIFTL, 5 bits wide;
  - `sel_ula` constants;
  - the state enum.
  - The register modules share the code constants.
- One sub-module, `contador_iter`: iteration counter with clear, increment and terminal-count flag at `N_BITS`-1. It is instantiated only under `UNIDADE_CONTROLE_MUL_EN`.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles mid-MUL → next cycle state IDLE, all codes HOLD=2, sel_ula=PASS, busy=0, done=0, and no done pulse follows.
- ADD: opcode=3, start pulse → exactly one cycle ty=1, sel_ula=0; done=1 on the following cycle; busy high for exactly those 2 cycles.
- SHL then SUB back-to-back: restart in the first IDLE cycle → ty=3 one cycle, then ty=1 with sel_ula=1 one cycle; no extra HOLD gaps beyond DONE/IDLE.
- MUL with `N_BITS`=5, mult_bit pattern 1,0,1,1,0:
  - ty sequence 0, then 3/1, 3/2, 3/1, 3/1, 3/2;
  - tx=3 in each MUL_ADD;
  - done at cycle 12.
- start asserted while busy (during MUL) → ignored; only one done pulse.
- Build without `UNIDADE_CONTROLE_MUL_EN`: opcode 6 → 2-cycle NOP with all codes HOLD; opcode 7 → NOP in both builds.
